// File: rtl/discharge_pkg.sv
// rtl/discharge_pkg.sv - shared state encoding and waveform codes for the discharge run sequencer
package discharge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_STARTING = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_STOPPING = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam logic [15:0] WF_RES  = 16'h8000;
    localparam logic [15:0] WF_RECT = 16'h0001;
    localparam logic [15:0] WF_TRI  = 16'h0002;

    function automatic logic wf_legal(input logic [15:0] code);
        return (code == WF_RES) || (code == WF_RECT) || (code == WF_TRI);
    endfunction

endpackage

// File: rtl/discharge_run_sequencer_if.sv
// rtl/discharge_run_sequencer_if.sv - request, parameter-write and status bundle of the run sequencer
interface discharge_run_sequencer_if;

    logic        start_spi;
    logic        stop_spi;
    logic        start_key;
    logic        stop_key;
    logic        fault;
    logic        fault_clear;
    logic        is_operation;
    logic        cycle_end;
    logic        wr_ton;
    logic        wr_toff;
    logic        wr_ip;
    logic        wr_wf;
    logic [15:0] wr_data;

    logic        is_machine;
    logic [15:0] Ton;
    logic [15:0] Toff;
    logic [15:0] Ip;
    logic [15:0] waveform;
    logic        commit_pending;
    logic        param_err;
    logic        fault_latched;
    logic [2:0]  state;

    modport master (
        output start_spi, stop_spi, start_key, stop_key, fault, fault_clear,
               is_operation, cycle_end, wr_ton, wr_toff, wr_ip, wr_wf, wr_data,
        input  is_machine, Ton, Toff, Ip, waveform, commit_pending, param_err,
               fault_latched, state
    );

    modport slave (
        input  start_spi, stop_spi, start_key, stop_key, fault, fault_clear,
               is_operation, cycle_end, wr_ton, wr_toff, wr_ip, wr_wf, wr_data,
        output is_machine, Ton, Toff, Ip, waveform, commit_pending, param_err,
               fault_latched, state
    );

endinterface

// File: rtl/param_shadow_bank.sv
// rtl/param_shadow_bank.sv - validated shadow registers with atomic commit into the active pulse parameters
module param_shadow_bank
    import discharge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ton,
    input  logic        wr_toff,
    input  logic        wr_ip,
    input  logic        wr_wf,
    input  logic [15:0] wr_data,
    input  logic        commit,
    output logic [15:0] ton,
    output logic [15:0] toff,
    output logic [15:0] ip,
    output logic [15:0] waveform,
    output logic        commit_pending,
    output logic        param_err
);

    logic [15:0] sh_ton, sh_toff, sh_ip, sh_wf;
    logic [15:0] sh_ton_d, sh_toff_d, sh_ip_d, sh_wf_d;
    logic [15:0] ton_d, toff_d, ip_d, wf_d;
    logic        err_d, pending_d;
    logic        accepted, rejected;

    always_comb begin
        sh_ton_d  = sh_ton;
        sh_toff_d = sh_toff;
        sh_ip_d   = sh_ip;
        sh_wf_d   = sh_wf;
        accepted  = 1'b0;
        rejected  = 1'b0;

        if (wr_ton) begin
            if (wr_data != 16'd0) begin
                sh_ton_d = wr_data;
                accepted = 1'b1;
            end else begin
                rejected = 1'b1;
            end
        end
        if (wr_toff) begin
            if (wr_data != 16'd0) begin
                sh_toff_d = wr_data;
                accepted  = 1'b1;
            end else begin
                rejected = 1'b1;
            end
        end
        if (wr_ip) begin
            sh_ip_d  = wr_data;
            accepted = 1'b1;
        end
        if (wr_wf) begin
            if (wf_legal(wr_data)) begin
                sh_wf_d  = wr_data;
                accepted = 1'b1;
            end else begin
                rejected = 1'b1;
            end
        end

        // A rejection anywhere in the cycle keeps the error flag up, even if a sibling write landed.
        err_d = param_err;
        if (rejected) begin
            err_d = 1'b1;
        end else if (accepted) begin
            err_d = 1'b0;
        end

        // Commit takes the shadow as it stood before this cycle's writes.
        ton_d  = commit ? sh_ton  : ton;
        toff_d = commit ? sh_toff : toff;
        ip_d   = commit ? sh_ip   : ip;
        wf_d   = commit ? sh_wf   : waveform;

        pending_d = {sh_ton_d, sh_toff_d, sh_ip_d, sh_wf_d} != {ton_d, toff_d, ip_d, wf_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ton         <= 16'd0;
            sh_toff        <= 16'd0;
            sh_ip          <= 16'd0;
            sh_wf          <= WF_RECT;
            ton            <= 16'd0;
            toff           <= 16'd0;
            ip             <= 16'd0;
            waveform       <= WF_RECT;
            param_err      <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            sh_ton         <= sh_ton_d;
            sh_toff        <= sh_toff_d;
            sh_ip          <= sh_ip_d;
            sh_wf          <= sh_wf_d;
            ton            <= ton_d;
            toff           <= toff_d;
            ip             <= ip_d;
            waveform       <= wf_d;
            param_err      <= err_d;
            commit_pending <= pending_d;
        end
    end

endmodule

// File: rtl/discharge_run_sequencer.sv
// rtl/discharge_run_sequencer.sv - run gate, start/soft-stop/fault FSM and parameter commit control
module discharge_run_sequencer
    import discharge_pkg::*;
#(
    parameter logic [15:0] START_DELAY  = 16'd100,
    parameter logic [15:0] STOP_TIMEOUT = 16'd20000
) (
    input  logic                       clk,
    input  logic                       rst,
    discharge_run_sequencer_if.slave   bus
);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        spi_en_q, spi_en_d, key_en_q, key_en_d;
    logic        spi_gate, key_gate;
    logic        run_req;
    logic        params_valid;
    logic        fault_exit;
    logic        commit;
    logic [15:0] ton, toff, ip, waveform;
    logic        commit_pending, param_err;

    assign params_valid = (ton != 16'd0) && (toff != 16'd0);
    assign commit = commit_pending &&
                    ((state_q == ST_IDLE) || ((state_q == ST_RUNNING) && bus.cycle_end));

    always_comb begin
        // Stop is applied after start so a same-cycle pair leaves the source disabled.
        spi_gate = spi_en_q;
        if (bus.start_spi) spi_gate = 1'b1;
        if (bus.stop_spi)  spi_gate = 1'b0;
        key_gate = key_en_q;
        if (bus.start_key) key_gate = 1'b1;
        if (bus.stop_key)  key_gate = 1'b0;

        // Gate from the updated enables so a strobe acts on the FSM at the same edge.
        run_req = spi_gate && key_gate;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_req && params_valid && (state_q != ST_FAULT)) state_d = ST_STARTING;
            end
            ST_STARTING: begin
                if (!run_req)                          state_d = ST_IDLE;
                else if (cnt_q == START_DELAY - 16'd1) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!run_req) state_d = ST_STOPPING;
            end
            ST_STOPPING: begin
                if (!bus.is_operation)                  state_d = ST_IDLE;
                else if (cnt_q == STOP_TIMEOUT - 16'd1) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.fault_clear && !bus.is_operation) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.fault) state_d = ST_FAULT;

        // Leaving FAULT demands a fresh start from both sources.
        fault_exit = (state_q == ST_FAULT) && (state_d == ST_IDLE);
        spi_en_d   = fault_exit ? 1'b0 : spi_gate;
        key_en_d   = fault_exit ? 1'b0 : key_gate;

        if (state_d != state_q)     cnt_d = 16'd0;
        else if (cnt_q == 16'hFFFF) cnt_d = cnt_q;
        else                        cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 16'd0;
            spi_en_q <= 1'b0;
            key_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spi_en_q <= spi_en_d;
            key_en_q <= key_en_d;
        end
    end

    param_shadow_bank u_shadow (
        .clk            (clk),
        .rst            (rst),
        .wr_ton         (bus.wr_ton),
        .wr_toff        (bus.wr_toff),
        .wr_ip          (bus.wr_ip),
        .wr_wf          (bus.wr_wf),
        .wr_data        (bus.wr_data),
        .commit         (commit),
        .ton            (ton),
        .toff           (toff),
        .ip             (ip),
        .waveform       (waveform),
        .commit_pending (commit_pending),
        .param_err      (param_err)
    );

    assign bus.is_machine     = (state_q == ST_RUNNING);
    assign bus.fault_latched  = (state_q == ST_FAULT);
    assign bus.state          = state_q;
    assign bus.Ton            = ton;
    assign bus.Toff           = toff;
    assign bus.Ip             = ip;
    assign bus.waveform       = waveform;
    assign bus.commit_pending = commit_pending;
    assign bus.param_err      = param_err;

endmodule

// File: tb/tb_discharge_run_sequencer.sv
// tb/tb_discharge_run_sequencer.sv - randomized self-checking bench for discharge_run_sequencer
module tb_discharge_run_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    discharge_run_sequencer_if bus ();

    discharge_run_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference: shadow and active parameter sets, plus expected sticky error.
    logic [15:0] m_sh  [4];
    logic [15:0] m_act [4];
    logic        m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit legal(input int k, input logic [15:0] d);
        if (k == 0 || k == 1) return d != 16'd0;
        if (k == 2)           return 1'b1;
        return (d == 16'h8000) || (d == 16'h0001) || (d == 16'h0002);
    endfunction

    function automatic logic [15:0] dut_param(input int k);
        case (k)
            0:       return bus.Ton;
            1:       return bus.Toff;
            2:       return bus.Ip;
            default: return bus.waveform;
        endcase
    endfunction

    function automatic bit model_pending();
        for (int k = 0; k < 4; k++) if (m_sh[k] != m_act[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        bus.start_spi = 0; bus.stop_spi = 0; bus.start_key = 0; bus.stop_key = 0;
        bus.fault = 0; bus.fault_clear = 0; bus.is_operation = 0; bus.cycle_end = 0;
        bus.wr_ton = 0; bus.wr_toff = 0; bus.wr_ip = 0; bus.wr_wf = 0; bus.wr_data = 16'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_sh  = '{16'd0, 16'd0, 16'd0, 16'h0001};
        m_act = '{16'd0, 16'd0, 16'd0, 16'h0001};
        m_err = 1'b0;
    endtask

    // mask bit k strobes parameter k (0=Ton 1=Toff 2=Ip 3=waveform)
    task automatic wr_param(input int mask, input logic [15:0] d);
        bit acc = 0, rej = 0;
        bus.wr_ton = mask[0]; bus.wr_toff = mask[1]; bus.wr_ip = mask[2]; bus.wr_wf = mask[3];
        bus.wr_data = d;
        tick();
        bus.wr_ton = 0; bus.wr_toff = 0; bus.wr_ip = 0; bus.wr_wf = 0;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                if (legal(k, d)) begin m_sh[k] = d; acc = 1; end
                else rej = 1;
            end
        end
        if (rej) m_err = 1'b1;
        else if (acc) m_err = 1'b0;
    endtask

    task automatic strobe_start(input bit spi, input bit key);
        bus.start_spi = spi; bus.start_key = key;
        tick();
        bus.start_spi = 0; bus.start_key = 0;
    endtask

    task automatic go_running();
        int n = 0;
        do_reset();
        wr_param(1, 16'($urandom_range(1, 1000)));
        wr_param(2, 16'($urandom_range(1, 1000)));
        tick(); tick();
        m_act = m_sh;
        strobe_start(1, 0);
        strobe_start(0, 1);
        while (n < 200 && bus.is_machine !== 1'b1) begin tick(); n++; end
        checks++;
        if (bus.is_machine !== 1'b1) begin
            errors++; $display("FAIL go_running_timeout: is_machine=%0b after %0d cycles, want 1", bus.is_machine, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        checks++; if (bus.state !== 3'd0)     begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.is_machine !== 1'b0) begin errors++; $display("FAIL reset_is_machine: got %0b want 0", bus.is_machine); end
        checks++; if ({bus.Ton, bus.Toff, bus.Ip} !== 48'd0) begin errors++; $display("FAIL reset_params: got %0h/%0h/%0h want 0/0/0", bus.Ton, bus.Toff, bus.Ip); end
        checks++; if (bus.waveform !== 16'h0001) begin errors++; $display("FAIL reset_waveform: got %0h want 1", bus.waveform); end
        checks++; if ({bus.commit_pending, bus.param_err, bus.fault_latched} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got pend=%0b err=%0b flt=%0b want 000", bus.commit_pending, bus.param_err, bus.fault_latched);
        end
        do_reset();
    endtask

    task automatic test_rejected();
        do_reset();
        wr_param(8, 16'h0004);
        checks++; if (bus.param_err !== 1'b1) begin errors++; $display("FAIL rej_wf_err: got %0b want 1", bus.param_err); end
        tick();
        checks++; if (bus.waveform !== 16'h0001 || bus.commit_pending !== 1'b0) begin
            errors++; $display("FAIL rej_wf_unchanged: got wf=%0h pend=%0b want 1/0", bus.waveform, bus.commit_pending);
        end
        wr_param(1, 16'd0);
        checks++; if (bus.param_err !== 1'b1) begin errors++; $display("FAIL rej_ton_err: got %0b want 1", bus.param_err); end
        tick();
        checks++; if (bus.Ton !== 16'd0) begin errors++; $display("FAIL rej_ton_unchanged: got %0h want 0", bus.Ton); end
        wr_param(1, 16'd20);
        checks++; if (bus.param_err !== 1'b0) begin errors++; $display("FAIL acc_ton_clears_err: got %0b want 0", bus.param_err); end
        tick();
        m_act = m_sh;
        checks++; if (bus.Ton !== 16'd20) begin errors++; $display("FAIL acc_ton_commit: got %0h want 20", bus.Ton); end

        for (int i = 0; i < 24; i++) begin
            int mask = $urandom_range(1, 15);
            int sel  = $urandom_range(0, 3);
            logic [15:0] d;
            logic [15:0] wfs [3];
            wfs = '{16'h8000, 16'h0001, 16'h0002};
            case (sel)
                0:       d = 16'd0;
                1:       d = wfs[$urandom_range(0, 2)];
                2:       d = 16'($urandom_range(0, 65535));
                default: d = 16'($urandom_range(1, 8));
            endcase
            wr_param(mask, d);
            checks++; if (bus.param_err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %0b want %0b", i, bus.param_err, m_err); end
            checks++; if (bus.commit_pending !== model_pending()) begin
                errors++; $display("FAIL rand_pending[%0d]: got %0b want %0b", i, bus.commit_pending, model_pending());
            end
            tick();
            m_act = m_sh;
            for (int k = 0; k < 4; k++) begin
                checks++; if (dut_param(k) !== m_act[k]) begin
                    errors++; $display("FAIL rand_param[%0d][%0d]: got %0h want %0h", i, k, dut_param(k), m_act[k]);
                end
            end
        end
    endtask

    task automatic test_start();
        int n = 0;
        do_reset();
        wr_param(1, 16'd10);
        wr_param(2, 16'd50);
        wr_param(8, 16'h0001);
        tick(); tick();
        checks++; if (bus.Ton !== 16'd10 || bus.Toff !== 16'd50) begin
            errors++; $display("FAIL start_params: got %0d/%0d want 10/50", bus.Ton, bus.Toff);
        end
        strobe_start(1, 0);
        repeat (4) tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL start_spi_only: got state %0d want 0", bus.state); end
        strobe_start(0, 1);
        checks++; if (bus.state !== 3'd1 || bus.is_machine !== 1'b0) begin
            errors++; $display("FAIL start_entry: got state %0d mach %0b want 1/0", bus.state, bus.is_machine);
        end
        while (n < 200 && bus.is_machine !== 1'b1) begin tick(); n++; end
        checks++; if (n != 100) begin errors++; $display("FAIL start_delay: got %0d cycles want 100", n); end
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_running: got state %0d want 2", bus.state); end
    endtask

    task automatic test_commit_boundary();
        go_running();
        for (int r = 0; r < 4; r++) begin
            logic [15:0] old_ton = bus.Ton;
            logic [15:0] old_ip  = bus.Ip;
            logic [15:0] nt = 16'($urandom_range(1, 65535));
            logic [15:0] ni = (r == 0) ? 16'd40 : 16'($urandom_range(0, 65535));
            if (nt == old_ton) nt = nt ^ 16'h0100;
            if (ni == old_ip)  ni = ni ^ 16'h0001;
            if (r > 0) wr_param(1, nt);
            wr_param(4, ni);
            checks++; if (bus.commit_pending !== 1'b1) begin errors++; $display("FAIL cb_pending[%0d]: got %0b want 1", r, bus.commit_pending); end
            repeat ($urandom_range(3, 20)) tick();
            checks++; if (bus.Ip !== old_ip || bus.Ton !== old_ton) begin
                errors++; $display("FAIL cb_hold[%0d]: got Ton=%0h Ip=%0h want %0h/%0h", r, bus.Ton, bus.Ip, old_ton, old_ip);
            end
            bus.cycle_end = 1;
            tick();
            bus.cycle_end = 0;
            m_act = m_sh;
            checks++; if (bus.Ip !== m_act[2] || bus.Ton !== m_act[0]) begin
                errors++; $display("FAIL cb_commit[%0d]: got Ton=%0h Ip=%0h want %0h/%0h", r, bus.Ton, bus.Ip, m_act[0], m_act[2]);
            end
            checks++; if (bus.commit_pending !== 1'b0) begin errors++; $display("FAIL cb_pending_clr[%0d]: got %0b want 0", r, bus.commit_pending); end
        end
    endtask

    task automatic test_soft_stop();
        int n = 0;
        go_running();
        bus.is_operation = 1;
        bus.stop_key = 1; tick(); bus.stop_key = 0;
        checks++; if (bus.is_machine !== 1'b0 || bus.state !== 3'd3) begin
            errors++; $display("FAIL stop_entry: got mach %0b state %0d want 0/3", bus.is_machine, bus.state);
        end
        repeat (300) tick();
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL stop_hold: got state %0d want 3", bus.state); end
        bus.is_operation = 0;
        tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL stop_idle: got state %0d want 0", bus.state); end

        strobe_start(0, 1);
        while (n < 200 && bus.is_machine !== 1'b1) begin tick(); n++; end
        checks++; if (bus.is_machine !== 1'b1) begin errors++; $display("FAIL stop_restart: got mach %0b want 1", bus.is_machine); end
        bus.is_operation = 1;
        bus.stop_spi = 1; tick(); bus.stop_spi = 0;
        n = 0;
        while (n < 20100 && bus.state !== 3'd4) begin tick(); n++; end
        checks++; if (n != 20000) begin errors++; $display("FAIL stop_timeout: got %0d cycles want 20000", n); end
        checks++; if (bus.fault_latched !== 1'b1) begin errors++; $display("FAIL stop_timeout_latch: got %0b want 1", bus.fault_latched); end
        bus.is_operation = 0;
        bus.fault_clear = 1; tick(); bus.fault_clear = 0;
    endtask

    task automatic test_fault();
        go_running();
        repeat ($urandom_range(1, 30)) tick();
        bus.fault = 1; tick(); bus.fault = 0;
        checks++; if (bus.is_machine !== 1'b0 || bus.fault_latched !== 1'b1 || bus.state !== 3'd4) begin
            errors++; $display("FAIL fault_entry: got mach %0b latch %0b state %0d want 0/1/4", bus.is_machine, bus.fault_latched, bus.state);
        end
        bus.is_operation = 1;
        bus.fault_clear = 1; tick(); bus.fault_clear = 0;
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL fault_clear_busy: got state %0d want 4", bus.state); end
        bus.is_operation = 0;
        bus.fault_clear = 1; tick(); bus.fault_clear = 0;
        checks++; if (bus.state !== 3'd0 || bus.fault_latched !== 1'b0) begin
            errors++; $display("FAIL fault_clear: got state %0d latch %0b want 0/0", bus.state, bus.fault_latched);
        end
        strobe_start(1, 0);
        repeat (3) tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL fault_gate_cleared: got state %0d want 0", bus.state); end
        strobe_start(0, 1);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL fault_restart: got state %0d want 1", bus.state); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wr_param(1, 16'd7);
        wr_param(2, 16'd9);
        tick(); tick();
        strobe_start(0, 1);
        bus.start_spi = 1; bus.stop_spi = 1; tick(); bus.start_spi = 0; bus.stop_spi = 0;
        repeat (3) tick();
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL sim_stop_wins: got state %0d want 0", bus.state); end
        strobe_start(1, 0);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL sim_then_start: got state %0d want 1", bus.state); end

        go_running();
        wr_param(4, 16'h1234);
        rst = 1'b1;
        tick();
        checks++; if (bus.is_machine !== 1'b0 || bus.state !== 3'd0) begin
            errors++; $display("FAIL midrun_reset_fsm: got mach %0b state %0d want 0/0", bus.is_machine, bus.state);
        end
        checks++; if ({bus.Ton, bus.Toff, bus.Ip, bus.waveform} !== {16'd0, 16'd0, 16'd0, 16'h0001}) begin
            errors++; $display("FAIL midrun_reset_params: got %0h/%0h/%0h/%0h want 0/0/0/1", bus.Ton, bus.Toff, bus.Ip, bus.waveform);
        end
        checks++; if ({bus.commit_pending, bus.param_err, bus.fault_latched} !== 3'b000) begin
            errors++; $display("FAIL midrun_reset_flags: got %0b%0b%0b want 000", bus.commit_pending, bus.param_err, bus.fault_latched);
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rejected();
        test_start();
        test_commit_boundary();
        test_soft_stop();
        test_fault();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
